addsub_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one WIDTH-bit ripple-carry add/subtract datapath between two requesters. It accepts an operation (a, b, mode) from one requester at a time, executes it on the shared datapath, and returns a registered result tagged with the requester ID over a valid/ready response channel. It sits between the two client blocks and the single add/sub unit, so that only one copy of that unit is needed.

---
 rtl/addsub_arbiter.sv | 138 +++++++++++++
 tb/tb_addsub_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end for a single shared ripple-carry add/sub unit.
// Each operation passes through three phases: accept (IDLE), execute (EXEC), respond (RESP).
module addsub_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_s,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_q, state_d;
  logic               prio_q, prio_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               mode_q, mode_d, id_q, id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]   rsp_s_q, rsp_s_d;
  logic               rsp_cout_q, rsp_cout_d;
  logic               rsp_ovf_q, rsp_ovf_d;
  logic [CNT_W-1:0]   ops_q, ops_d;

  // Shared datapath: subtract is a + ~b + 1 through the same carry chain.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] bx, sum;
  assign bx   = b_q ^ {WIDTH{mode_q}};
  assign c[0] = mode_q;
  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    assign sum[i]   = a_q[i] ^ bx[i] ^ c[i];
    assign c[i+1]   = (a_q[i] & bx[i]) | (c[i] & (a_q[i] ^ bx[i]));
  end

  logic gnt0, gnt1;
  assign gnt0 = (state_q == IDLE) && req0_valid && (!req1_valid || !prio_q);
  assign gnt1 = (state_q == IDLE) && req1_valid && (!req0_valid ||  prio_q);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_s_d     = rsp_s_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    ops_d       = ops_q;
    case (state_q)
      IDLE: begin
        if (gnt0) begin
          a_d = req0_a; b_d = req0_b; mode_d = req0_mode; id_d = 1'b0;
          prio_d  = 1'b1;
          state_d = EXEC;
        end else if (gnt1) begin
          a_d = req1_a; b_d = req1_b; mode_d = req1_mode; id_d = 1'b1;
          prio_d  = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_s_d     = sum;
        rsp_cout_d  = c[WIDTH];
        rsp_ovf_d   = c[WIDTH] ^ c[WIDTH-1];
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          ops_d       = ops_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      id_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_s_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      ops_q       <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_s_q     <= rsp_s_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      ops_q       <= ops_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_s      = rsp_s_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign ops_done   = ops_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter; a second instance with a 2-bit counter shares
// all inputs so the ops_done wrap is observed on the same traffic.
module tb_addsub_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_mode, req1_mode, rsp_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_ovf;
  logic [3:0] rsp_s;
  logic [7:0] ops_done;
  logic       w_r0, w_r1, w_v, w_id, w_c, w_o;
  logic [3:0] w_s;
  logic [1:0] w_ops;

  int n_vec = 0;
  int n_err = 0;
  int cnt   = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .ops_done(ops_done));

  addsub_arbiter #(.WIDTH(4), .CNT_W(2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(w_r0), .req0_a(req0_a), .req0_b(req0_b), .req0_mode(req0_mode),
    .req1_valid(req1_valid), .req1_ready(w_r1), .req1_a(req1_a), .req1_b(req1_b), .req1_mode(req1_mode),
    .rsp_valid(w_v), .rsp_ready(rsp_ready), .rsp_id(w_id), .rsp_s(w_s),
    .rsp_cout(w_c), .rsp_ovf(w_o), .ops_done(w_ops));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic id,
                         input logic [3:0] s, input logic co, input logic ov);
    chk({tag, ".valid"}, {31'd0, rsp_valid}, {31'd0, v});
    chk({tag, ".id"},    {31'd0, rsp_id},    {31'd0, id});
    chk({tag, ".s"},     {28'd0, rsp_s},     {28'd0, s});
    chk({tag, ".cout"},  {31'd0, rsp_cout},  {31'd0, co});
    chk({tag, ".ovf"},   {31'd0, rsp_ovf},   {31'd0, ov});
    chk({tag, ".w"},     {24'd0, w_v, w_id, w_s, w_c, w_o}, {24'd0, v, id, s, co, ov});
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    chk({tag, ".rdy"}, {30'd0, req0_ready, req1_ready}, {30'd0, r0, r1});
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, ".ops"},   {24'd0, ops_done}, cnt % 256);
    chk({tag, ".ops_w"}, {30'd0, w_ops},    cnt % 4);
  endtask

  // Single-requester op with rsp_ready high; starts and ends at a negedge in IDLE.
  task automatic one_op(input string tag, input logic id, input logic [3:0] a, input logic [3:0] b,
                        input logic m, input logic [3:0] s, input logic co, input logic ov);
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_mode = m; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_mode = m; end
    rsp_ready = 1;
    #1 chk_rdy({tag, ".acc"}, !id, id);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    #1 chk_rdy({tag, ".exec"}, 0, 0);
    chk({tag, ".exec_v"}, {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk_rsp({tag, ".rsp"}, 1, id, s, co, ov);
    @(negedge clk);
    cnt++;
    chk_cnt(tag);
    chk({tag, ".idle_v"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 0; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_mode = 0; req1_a = 0; req1_b = 0; req1_mode = 0;
    @(negedge clk); @(negedge clk);
    chk_rsp("reset", 0, 0, 4'd0, 0, 0);
    chk_rdy("reset", 0, 0);
    chk_cnt("reset");
    rst_n = 1;
    @(negedge clk);

    one_op("add5p3", 0, 4'd5, 4'd3, 0, 4'd8, 0, 1);
    one_op("sub7m2", 1, 4'd7, 4'd2, 1, 4'd5, 1, 0);
    one_op("sub3m5", 1, 4'd3, 4'd5, 1, 4'd14, 0, 0);

    // Backpressure: requester 1 waits while the response is stalled
    req0_valid = 1; req0_a = 4'd2; req0_b = 4'd4; req0_mode = 0; rsp_ready = 0;
    #1 chk_rdy("bp.acc", 1, 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 1; req1_a = 4'd1; req1_b = 4'd1; req1_mode = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk_rsp("bp.hold", 1, 0, 4'd6, 0, 0);
      chk_rdy("bp.hold", 0, 0);
      chk_cnt("bp.hold");
    end
    rsp_ready = 1;
    @(negedge clk);
    req1_valid = 0;
    cnt++;
    chk_cnt("bp.rel");
    chk({"bp.rel_v"}, {31'd0, rsp_valid}, 32'd0);

    // Contention from reset: strict alternation, one grant every 3 cycles
    rst_n = 0; #1;
    cnt = 0;
    chk_cnt("rst2");
    @(negedge clk);
    rst_n = 1;
    req0_valid = 1; req0_a = 4'd1; req0_b = 4'd1; req0_mode = 0;
    req1_valid = 1; req1_a = 4'd6; req1_b = 4'd1; req1_mode = 1;
    for (int g = 0; g < 4; g++) begin
      #1 chk_rdy("cont.acc", g % 2 == 0, g % 2 == 1);
      @(negedge clk);
      chk_rdy("cont.exec", 0, 0);
      @(negedge clk);
      chk_rdy("cont.resp", 0, 0);
      if (g % 2 == 0) chk_rsp("cont.rsp0", 1, 0, 4'd2, 0, 0);
      else            chk_rsp("cont.rsp1", 1, 1, 4'd5, 1, 0);
      @(negedge clk);
      cnt++;
      chk_cnt("cont");
    end
    req0_valid = 0; req1_valid = 0;

    // Fifth op wraps the 2-bit counter to 1 and leaves prio pointing at requester 1
    one_op("wrap", 0, 4'd9, 4'd9, 0, 4'd2, 1, 1);

    // Reset during EXEC: response discarded, prio back to requester 0
    req0_valid = 1; req0_a = 4'd4; req0_b = 4'd1; req0_mode = 0;
    @(negedge clk);
    req0_valid = 0;
    rst_n = 0; #1;
    cnt = 0;
    chk_rsp("rst_exec", 0, 0, 4'd0, 0, 0);
    chk_cnt("rst_exec");
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    chk_rsp("rst_exec.hold", 0, 0, 4'd0, 0, 0);
    req0_valid = 1; req0_a = 4'd1; req0_b = 4'd1; req0_mode = 0;
    req1_valid = 1; req1_a = 4'd6; req1_b = 4'd1; req1_mode = 1;
    #1 chk_rdy("rst_exec.prio", 1, 0);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    chk_rsp("rst_exec.rsp", 1, 0, 4'd2, 0, 0);
    @(negedge clk);
    cnt++;
    chk_cnt("rst_exec.done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
